multiplier_booth: RTL and testbench

MULTIPLIER_BOOTH -- requirements
Module: multiplier_booth

---
 rtl/multdiv_pkg.sv | 34 +++
 rtl/booth_recode.sv | 30 +++
 rtl/multiplier_booth.sv | 96 +++++++++
 tb/tb_multiplier_booth.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared widths, FSM states and radix-4 Booth select encoding for the multiplier
package multdiv_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 16;
    localparam int CNT_WIDTH  = 6;
    localparam int ACC_WIDTH  = MULT_WIDTH + 2;
    localparam int PROD_WIDTH = ACC_WIDTH + MULT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_e;

    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_POS1,
        BOOTH_POS2,
        BOOTH_NEG1,
        BOOTH_NEG2
    } booth_sel_e;

    function automatic booth_sel_e booth_select(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BOOTH_POS1;
            3'b011:         return BOOTH_POS2;
            3'b100:         return BOOTH_NEG2;
            3'b101, 3'b110: return BOOTH_NEG1;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_recode.sv
// rtl/booth_recode.sv - radix-4 Booth digit decode into negate/double/zero controls
import multdiv_pkg::*;

module booth_recode (
    input  logic [2:0] bits,
    output logic       neg,
    output logic       dbl,
    output logic       zero
);

    booth_sel_e sel;

    always_comb begin
        sel  = booth_select(bits);
        neg  = 1'b0;
        dbl  = 1'b0;
        zero = 1'b0;
        case (sel)
            BOOTH_POS1: ;
            BOOTH_POS2: dbl = 1'b1;
            BOOTH_NEG1: neg = 1'b1;
            BOOTH_NEG2: begin
                neg = 1'b1;
                dbl = 1'b1;
            end
            default:    zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/multiplier_booth.sv
// rtl/multiplier_booth.sv - 16-cycle radix-4 Booth signed multiplier; MULT_EXCEPTION_EN enables overflow flag
import multdiv_pkg::*;

module multiplier_booth (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MULT_WIDTH-1:0] data_operandA,
    input  logic [MULT_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    output logic [MULT_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic [CNT_WIDTH-1:0]  counter
);

    mult_state_e state, next_state;

    logic [MULT_WIDTH-1:0]        a_reg;
    logic [PROD_WIDTH-1:0]        prod;
    logic                         neg, dbl, zero;
    logic signed [ACC_WIDTH-1:0]  a_ext, a_mag, addend, upper_sum;
    logic signed [PROD_WIDTH-1:0] sum_prod, next_prod;
    logic                         last_step;

    booth_recode u_booth_recode (
        .bits (prod[2:0]),
        .neg  (neg),
        .dbl  (dbl),
        .zero (zero)
    );

    // Two guard bits let +/-2A of the most negative operand fit without wrapping.
    always_comb begin
        a_ext     = {{2{a_reg[MULT_WIDTH-1]}}, a_reg};
        a_mag     = dbl ? (a_ext <<< 1) : a_ext;
        addend    = zero ? '0 : (neg ? -a_mag : a_mag);
        upper_sum = prod[PROD_WIDTH-1 -: ACC_WIDTH] + addend;
        sum_prod  = {upper_sum, prod[MULT_WIDTH:0]};
        next_prod = sum_prod >>> 2;
    end

    assign last_step = (counter == CNT_WIDTH'(MULT_ITERS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_MULT) next_state = RUN;
            RUN:     if (ctrl_MULT) next_state = RUN;
                     else if (last_step) next_state = DONE;
            DONE:    next_state = ctrl_MULT ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Final product sits in prod[64:1]; the low half is captured on the step that completes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg       <= '0;
            prod        <= '0;
            counter     <= '0;
            data_result <= '0;
        end else if (ctrl_MULT) begin
            a_reg   <= data_operandA;
            prod    <= {{ACC_WIDTH{1'b0}}, data_operandB, 1'b0};
            counter <= '0;
        end else if (state == RUN) begin
            prod    <= next_prod;
            counter <= counter + 1'b1;
            if (last_step) data_result <= next_prod[MULT_WIDTH:1];
        end
    end

`ifdef MULT_EXCEPTION_EN
    logic exc_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exc_reg <= 1'b0;
        end else if (!ctrl_MULT && state == RUN && last_step) begin
            exc_reg <= (next_prod[2*MULT_WIDTH:MULT_WIDTH+1] != {MULT_WIDTH{next_prod[MULT_WIDTH]}});
        end
    end

    assign data_exception = exc_reg;
`else
    assign data_exception = 1'b0;
`endif

    assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multiplier_booth.sv
// tb/tb_multiplier_booth.sv - directed self-checking bench for multiplier_booth
module tb_multiplier_booth;

`ifdef MULT_EXCEPTION_EN
    localparam logic EXC_OVF = 1'b1;
`else
    localparam logic EXC_OVF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [5:0]  counter;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier_booth dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .counter        (counter)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = 32'hDEADBEEF;
        data_operandB = 32'h12345679;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] res, input logic exc);
        int cycles;
        cycles = 0;
        while (!data_resultRDY && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'd16);
        check({tag, "_result"}, {32'd0, data_result}, {32'd0, res});
        check({tag, "_exc"}, {63'd0, data_exception}, {63'd0, exc});
    endtask

    task automatic finish_op(input string tag, input logic [31:0] res, input logic exc);
        wait_done(tag, res, exc);
        @(negedge clock);
        check({tag, "_rdy_one_cycle"}, {63'd0, data_resultRDY}, 64'd0);
    endtask

    initial begin
        int  cycles;
        logic rdy_seen;

        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd3;
        repeat (3) @(negedge clock);
        check("reset_result",  {32'd0, data_result}, 64'd0);
        check("reset_exc",     {63'd0, data_exception}, 64'd0);
        check("reset_rdy",     {63'd0, data_resultRDY}, 64'd0);
        check("reset_counter", {58'd0, counter}, 64'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        check("post_reset_idle_counter", {58'd0, counter}, 64'd0);

        start_op(32'd7, 32'd3);
        finish_op("mul_7x3", 32'd21, 1'b0);
        repeat (3) @(negedge clock);
        check("idle_hold_result", {32'd0, data_result}, 64'd21);
        check("idle_no_rdy", {63'd0, data_resultRDY}, 64'd0);

        start_op(32'hFFFFFFFB, 32'd6);
        finish_op("mul_m5x6", 32'hFFFFFFE2, 1'b0);

        start_op(32'h80000000, 32'd1);
        finish_op("mul_min_x1", 32'h80000000, 1'b0);

        start_op(32'h7FFFFFFF, 32'd2);
        finish_op("mul_max_x2", 32'hFFFFFFFE, EXC_OVF);

        start_op(32'h80000000, 32'hFFFFFFFF);
        finish_op("mul_min_xm1", 32'h80000000, EXC_OVF);

        start_op(32'd7, 32'd3);
        cycles   = 0;
        rdy_seen = 1'b0;
        while (counter != 6'd5 && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (data_resultRDY) rdy_seen = 1'b1;
        end
        check("abort_reach_cnt5", {58'd0, counter}, 64'd5);
        start_op(32'd4, 32'd4);
        finish_op("abort_4x4", 32'd16, 1'b0);
        check("abort_no_early_rdy", {63'd0, rdy_seen}, 64'd0);

        start_op(32'd7, 32'd3);
        cycles = 0;
        while (counter != 6'd8 && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        check("midreset_reach_cnt8", {58'd0, counter}, 64'd8);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        #1;
        check("midreset_counter", {58'd0, counter}, 64'd0);
        check("midreset_result",  {32'd0, data_result}, 64'd0);
        check("midreset_exc",     {63'd0, data_exception}, 64'd0);
        check("midreset_rdy",     {63'd0, data_resultRDY}, 64'd0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        rdy_seen  = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen = 1'b1;
        end
        check("midreset_no_rdy", {63'd0, rdy_seen}, 64'd0);
        check("midreset_idle_counter", {58'd0, counter}, 64'd0);
        start_op(32'd2, 32'd3);
        finish_op("after_reset_2x3", 32'd6, 1'b0);

        start_op(32'd7, 32'd3);
        wait_done("b2b_first", 32'd21, 1'b0);
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("b2b_second", 32'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
